// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch types and constants (no build options)
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

   localparam int PC_W_DEFAULT = 10;

   // Halt encoding is shared with the control decoder so both sides agree on it.
   localparam logic [8:0] HALT_OPCODE = 9'h1FF;

   function automatic logic is_halt(input logic [8:0] opcode);
      return opcode == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next PC / next state priority select (no build options)
module pc_next_mux
   import fetch_pkg::*;
#(
   parameter int PC_W       = PC_W_DEFAULT,
   parameter int START_ADDR = 0,
   parameter int LAST_ADDR  = 2**PC_W - 1
) (
   input  fetch_state_t    state,
   input  logic [PC_W-1:0] pc,
   input  logic            start,
   input  logic            halt_req,
   input  logic            branch_en,
   input  logic            taken,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc_next,
   output fetch_state_t    state_next
);

   localparam logic [PC_W-1:0] START_PC = START_ADDR[PC_W-1:0];
   localparam logic [PC_W-1:0] LAST_PC  = LAST_ADDR[PC_W-1:0];

   always_comb begin
      pc_next    = pc;
      state_next = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               pc_next    = START_PC;
               state_next = RUN;
            end
         end
         RUN: begin
            // Halt outranks a taken branch; a taken branch outranks the end bound.
            if (halt_req) begin
               state_next = DONE;
            end else if (branch_en && taken) begin
               pc_next = target;
            end else if (pc == LAST_PC) begin
               state_next = DONE;
            end else begin
               pc_next = pc + 1'b1;
            end
         end
         default: begin
            pc_next    = '0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC register and IDLE/RUN/DONE sequencing
// Define FETCH_INSTR_COUNT_EN to add the saturating InstrCount output.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int PC_W       = PC_W_DEFAULT,
   parameter int START_ADDR = 0,
   parameter int LAST_ADDR  = 2**PC_W - 1
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            Start,
   input  logic            BranchEn,
   input  logic            Taken,
   input  logic [PC_W-1:0] Target,
   input  logic            HaltReq,
   output logic [PC_W-1:0] ProgCtr,
   output logic            Running,
   output logic            Done
`ifdef FETCH_INSTR_COUNT_EN
   ,
   output logic [15:0]     InstrCount
`endif
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [PC_W-1:0] pc_next;

   pc_next_mux #(
      .PC_W       (PC_W),
      .START_ADDR (START_ADDR),
      .LAST_ADDR  (LAST_ADDR)
   ) u_pc_next_mux (
      .state      (state),
      .pc         (ProgCtr),
      .start      (Start),
      .halt_req   (HaltReq),
      .branch_en  (BranchEn),
      .taken      (Taken),
      .target     (Target),
      .pc_next    (pc_next),
      .state_next (state_next)
   );

   // Running/Done are decoded from the next state so they line up with the state register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= IDLE;
         ProgCtr <= '0;
         Running <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state   <= state_next;
         ProgCtr <= pc_next;
         Running <= (state_next == RUN);
         Done    <= (state_next == DONE);
      end
   end

`ifdef FETCH_INSTR_COUNT_EN
   logic retire;
   logic accept_start;

   assign retire       = (state == RUN) && !HaltReq;
   assign accept_start = (state != RUN) && Start;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         InstrCount <= '0;
      end else if (accept_start) begin
         InstrCount <= '0;
      end else if (retire && (InstrCount != 16'hFFFF)) begin
         InstrCount <= InstrCount + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed bench for fetch_sequencer (honours FETCH_INSTR_COUNT_EN)
module tb_fetch_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, rst_c;
   logic       start, branch_en, taken, halt_req;
   logic [9:0] target;

   logic [9:0] pc_a, pc_b;
   logic [3:0] pc_c;
   logic       run_a, run_b, run_c;
   logic       done_a, done_b, done_c;
`ifdef FETCH_INSTR_COUNT_EN
   logic [15:0] cnt_a, cnt_b, cnt_c;
`endif

   int errors = 0;
   int checks = 0;

   // A: short program, B: START_ADDR=16 full range, C: 4-bit PC
   fetch_sequencer #(.PC_W(10), .START_ADDR(0), .LAST_ADDR(5)) u_a (
      .Clk(clk), .Reset_n(rst_a), .Start(start), .BranchEn(branch_en), .Taken(taken),
      .Target(target), .HaltReq(halt_req), .ProgCtr(pc_a), .Running(run_a), .Done(done_a)
`ifdef FETCH_INSTR_COUNT_EN
      , .InstrCount(cnt_a)
`endif
   );

   fetch_sequencer #(.PC_W(10), .START_ADDR(16)) u_b (
      .Clk(clk), .Reset_n(rst_b), .Start(start), .BranchEn(branch_en), .Taken(taken),
      .Target(target), .HaltReq(halt_req), .ProgCtr(pc_b), .Running(run_b), .Done(done_b)
`ifdef FETCH_INSTR_COUNT_EN
      , .InstrCount(cnt_b)
`endif
   );

   fetch_sequencer #(.PC_W(4), .START_ADDR(0), .LAST_ADDR(15)) u_c (
      .Clk(clk), .Reset_n(rst_c), .Start(start), .BranchEn(branch_en), .Taken(taken),
      .Target(target[3:0]), .HaltReq(halt_req), .ProgCtr(pc_c), .Running(run_c), .Done(done_c)
`ifdef FETCH_INSTR_COUNT_EN
      , .InstrCount(cnt_c)
`endif
   );

   task automatic test_reset;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      start = 1'b0; branch_en = 1'b0; taken = 1'b0; halt_req = 1'b0; target = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (pc_a !== 10'd0 || run_a !== 1'b0 || done_a !== 1'b0) begin
         errors++; $display("FAIL reset_a: pc=%0d run=%0b done=%0b, expected 0/0/0", pc_a, run_a, done_a);
      end
      checks++;
      if (pc_b !== 10'd0 || run_b !== 1'b0 || done_b !== 1'b0) begin
         errors++; $display("FAIL reset_b: pc=%0d run=%0b done=%0b, expected 0/0/0", pc_b, run_b, done_b);
      end
      checks++;
      if (pc_c !== 4'd0 || run_c !== 1'b0 || done_c !== 1'b0) begin
         errors++; $display("FAIL reset_c: pc=%0d run=%0b done=%0b, expected 0/0/0", pc_c, run_c, done_c);
      end
`ifdef FETCH_INSTR_COUNT_EN
      checks++;
      if (cnt_a !== 16'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a);
      end
`endif
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (pc_a !== 10'd0 || run_a !== 1'b0 || done_a !== 1'b0) begin
         errors++; $display("FAIL idle_hold: pc=%0d run=%0b done=%0b, expected 0/0/0", pc_a, run_a, done_a);
      end
   endtask

   task automatic test_straight_run;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (pc_a !== 10'(k) || run_a !== 1'b1 || done_a !== 1'b0) begin
            errors++; $display("FAIL run_step%0d: pc=%0d run=%0b done=%0b, expected %0d/1/0", k, pc_a, run_a, done_a, k);
         end
      end
      @(negedge clk);
      checks++;
      if (pc_a !== 10'd5 || run_a !== 1'b0 || done_a !== 1'b1) begin
         errors++; $display("FAIL run_done: pc=%0d run=%0b done=%0b, expected 5/0/1", pc_a, run_a, done_a);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (pc_a !== 10'd5 || done_a !== 1'b1) begin
         errors++; $display("FAIL done_hold: pc=%0d done=%0b, expected 5/1", pc_a, done_a);
      end
`ifdef FETCH_INSTR_COUNT_EN
      checks++;
      if (cnt_a !== 16'd6) begin
         errors++; $display("FAIL run_cnt: got %0d expected 6", cnt_a);
      end
`endif
   endtask

   task automatic test_branch;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (pc_a !== 10'd0 || run_a !== 1'b1 || done_a !== 1'b0) begin
         errors++; $display("FAIL restart_a: pc=%0d run=%0b done=%0b, expected 0/1/0", pc_a, run_a, done_a);
      end
      repeat (3) @(negedge clk);
      branch_en = 1'b1; taken = 1'b1; target = 10'd10;
      @(negedge clk);
      checks++;
      if (pc_a !== 10'd10) begin
         errors++; $display("FAIL br_taken: pc=%0d expected 10", pc_a);
      end
      target = 10'd3;
      @(negedge clk);
      taken = 1'b0; target = 10'd10;
      @(negedge clk);
      checks++;
      if (pc_a !== 10'd4) begin
         errors++; $display("FAIL br_not_taken: pc=%0d expected 4", pc_a);
      end
      branch_en = 1'b0; taken = 1'b1;
      @(negedge clk);
      checks++;
      if (pc_a !== 10'd5 || run_a !== 1'b1) begin
         errors++; $display("FAIL taken_no_branch: pc=%0d run=%0b expected 5/1", pc_a, run_a);
      end
      branch_en = 1'b1; taken = 1'b1; target = 10'd2;
      @(negedge clk);
      checks++;
      if (pc_a !== 10'd2 || run_a !== 1'b1 || done_a !== 1'b0) begin
         errors++; $display("FAIL br_at_last: pc=%0d run=%0b done=%0b expected 2/1/0", pc_a, run_a, done_a);
      end
      branch_en = 1'b0; taken = 1'b0; halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      checks++;
      if (pc_a !== 10'd2 || run_a !== 1'b0 || done_a !== 1'b1) begin
         errors++; $display("FAIL halt_a: pc=%0d run=%0b done=%0b expected 2/0/1", pc_a, run_a, done_a);
      end
`ifdef FETCH_INSTR_COUNT_EN
      checks++;
      if (cnt_a !== 16'd8) begin
         errors++; $display("FAIL branch_cnt: got %0d expected 8", cnt_a);
      end
`endif
      rst_a = 1'b0;
   endtask

   task automatic test_halt_priority;
      rst_c = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (pc_c !== 4'd7 || run_c !== 1'b1) begin
         errors++; $display("FAIL reach7: pc=%0d run=%0b expected 7/1", pc_c, run_c);
      end
      halt_req = 1'b1; branch_en = 1'b1; taken = 1'b1; target = 10'd2;
      @(negedge clk);
      halt_req = 1'b0; branch_en = 1'b0; taken = 1'b0;
      checks++;
      if (pc_c !== 4'd7 || run_c !== 1'b0 || done_c !== 1'b1) begin
         errors++; $display("FAIL halt_prio: pc=%0d run=%0b done=%0b expected 7/0/1", pc_c, run_c, done_c);
      end
`ifdef FETCH_INSTR_COUNT_EN
      checks++;
      if (cnt_c !== 16'd7) begin
         errors++; $display("FAIL halt_cnt: got %0d expected 7", cnt_c);
      end
`endif
      repeat (2) @(negedge clk);
      checks++;
      if (pc_c !== 4'd7 || done_c !== 1'b1) begin
         errors++; $display("FAIL halt_hold: pc=%0d done=%0b expected 7/1", pc_c, done_c);
      end
   endtask

   task automatic test_wrap_bound;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      branch_en = 1'b1; taken = 1'b1; target = 10'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (pc_c !== 4'd0 || run_c !== 1'b1) begin
         errors++; $display("FAIL spin: pc=%0d run=%0b expected 0/1", pc_c, run_c);
      end
      target = 10'd14;
      @(negedge clk);
      branch_en = 1'b0; taken = 1'b0;
      checks++;
      if (pc_c !== 4'd14) begin
         errors++; $display("FAIL br14: pc=%0d expected 14", pc_c);
      end
      @(negedge clk);
      checks++;
      if (pc_c !== 4'd15 || run_c !== 1'b1) begin
         errors++; $display("FAIL step15: pc=%0d run=%0b expected 15/1", pc_c, run_c);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (pc_c !== 4'd15 || run_c !== 1'b0 || done_c !== 1'b1) begin
         errors++; $display("FAIL no_wrap: pc=%0d run=%0b done=%0b expected 15/0/1", pc_c, run_c, done_c);
      end
`ifdef FETCH_INSTR_COUNT_EN
      checks++;
      if (cnt_c !== 16'd5) begin
         errors++; $display("FAIL wrap_cnt: got %0d expected 5", cnt_c);
      end
`endif
      rst_c = 1'b0;
   endtask

   task automatic test_reset_mid_run;
      rst_b = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (pc_b !== 10'd16 || run_b !== 1'b1 || done_b !== 1'b0) begin
         errors++; $display("FAIL start16: pc=%0d run=%0b done=%0b expected 16/1/0", pc_b, run_b, done_b);
      end
      repeat (26) @(negedge clk);
      checks++;
      if (pc_b !== 10'd42 || run_b !== 1'b1) begin
         errors++; $display("FAIL start_held: pc=%0d run=%0b expected 42/1", pc_b, run_b);
      end
      rst_b = 1'b0;
      start = 1'b0;
      #1;
      checks++;
      if (pc_b !== 10'd0 || run_b !== 1'b0 || done_b !== 1'b0) begin
         errors++; $display("FAIL async_rst: pc=%0d run=%0b done=%0b expected 0/0/0", pc_b, run_b, done_b);
      end
      @(negedge clk);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (pc_b !== 10'd0 || run_b !== 1'b0 || done_b !== 1'b0) begin
         errors++; $display("FAIL post_rst_idle: pc=%0d run=%0b done=%0b expected 0/0/0", pc_b, run_b, done_b);
      end
   endtask

   task automatic test_back_to_back;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      checks++;
      if (pc_b !== 10'd18 || done_b !== 1'b1 || run_b !== 1'b0) begin
         errors++; $display("FAIL halt_b: pc=%0d done=%0b run=%0b expected 18/1/0", pc_b, done_b, run_b);
      end
`ifdef FETCH_INSTR_COUNT_EN
      checks++;
      if (cnt_b !== 16'd2) begin
         errors++; $display("FAIL halt_b_cnt: got %0d expected 2", cnt_b);
      end
`endif
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (pc_b !== 10'd16 || run_b !== 1'b1 || done_b !== 1'b0) begin
         errors++; $display("FAIL restart_b: pc=%0d run=%0b done=%0b expected 16/1/0", pc_b, run_b, done_b);
      end
`ifdef FETCH_INSTR_COUNT_EN
      checks++;
      if (cnt_b !== 16'd0) begin
         errors++; $display("FAIL restart_cnt: got %0d expected 0", cnt_b);
      end
`endif
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (pc_b !== 10'd17 || run_b !== 1'b1) begin
         errors++; $display("FAIL no_reload: pc=%0d run=%0b expected 17/1", pc_b, run_b);
      end
   endtask

   initial begin
      test_reset();
      test_straight_run();
      test_branch();
      test_halt_priority();
      test_wrap_bound();
      test_reset_mid_run();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
